// File: rtl/mem_stage_hs.sv
// MIPS memory-access stage with a request/acknowledge data-memory handshake.
// Handles sub-word loads/stores, endian selection, alignment faults and bus timeout.
module mem_stage_hs #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter bit          BIG_ENDIAN = 1'b0,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid_i,
    input  logic [7:0]        aluop_i,
    input  logic [31:0]       wdata_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic              whilo_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic              cp0_reg_we_i,
    input  logic [4:0]        cp0_reg_write_addr_i,
    input  logic [31:0]       cp0_reg_data_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i,
    input  logic              mem_ack_i,
    output logic              stall_req_o,
    output logic              wb_valid_o,
    output logic [31:0]       wdata_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic              whilo_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic              cp0_reg_we_o,
    output logic [4:0]        cp0_reg_write_addr_o,
    output logic [31:0]       cp0_reg_data_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              bus_err_o,
    output logic [ADDR_W-1:0] badvaddr_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    logic [7:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       reg2_q, wdata_q, hi_q, lo_q, cp0_data_q;
    logic [REG_AW-1:0] wd_q;
    logic [4:0]        cp0_addr_q;
    logic              wreg_q, whilo_q, cp0_we_q;

    logic              in_wait;
    logic [7:0]        src_op;
    logic [ADDR_W-1:0] src_addr;
    logic [31:0]       src_reg2, src_wdata, src_hi, src_lo, src_cp0_data;
    logic [REG_AW-1:0] src_wd;
    logic [4:0]        src_cp0_addr;
    logic              src_wreg, src_whilo, src_cp0_we;

    // While waiting, every field comes from the copy latched at accept time.
    assign in_wait      = (state == S_WAIT);
    assign src_op       = in_wait ? op_q       : aluop_i;
    assign src_addr     = in_wait ? addr_q     : mem_addr_i;
    assign src_reg2     = in_wait ? reg2_q     : reg2_i;
    assign src_wdata    = in_wait ? wdata_q    : wdata_i;
    assign src_wd       = in_wait ? wd_q       : wd_i;
    assign src_wreg     = in_wait ? wreg_q     : wreg_i;
    assign src_whilo    = in_wait ? whilo_q    : whilo_i;
    assign src_hi       = in_wait ? hi_q       : hi_i;
    assign src_lo       = in_wait ? lo_q       : lo_i;
    assign src_cp0_we   = in_wait ? cp0_we_q   : cp0_reg_we_i;
    assign src_cp0_addr = in_wait ? cp0_addr_q : cp0_reg_write_addr_i;
    assign src_cp0_data = in_wait ? cp0_data_q : cp0_reg_data_i;

    logic        is_load, is_store, ld_signed, misaligned;
    logic [1:0]  size, lane, half_base, shamt;
    logic [3:0]  sel;
    logic [31:0] st_data, ld_sh, ld_ext;

    // Op decode, lane selection and load extraction
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        ld_signed = 1'b0;
        size      = 2'd2;
        case (src_op)
            OP_LB:   begin is_load  = 1'b1; size = 2'd0; ld_signed = 1'b1; end
            OP_LBU:  begin is_load  = 1'b1; size = 2'd0; end
            OP_LH:   begin is_load  = 1'b1; size = 2'd1; ld_signed = 1'b1; end
            OP_LHU:  begin is_load  = 1'b1; size = 2'd1; end
            OP_LW:   begin is_load  = 1'b1; size = 2'd2; end
            OP_SB:   begin is_store = 1'b1; size = 2'd0; end
            OP_SH:   begin is_store = 1'b1; size = 2'd1; end
            OP_SW:   begin is_store = 1'b1; size = 2'd2; end
            default: size = 2'd2;
        endcase

        misaligned = ((size == 2'd1) && src_addr[0]) ||
                     ((size == 2'd2) && (src_addr[1:0] != 2'b00));

        if (BIG_ENDIAN) begin
            lane      = 2'd3 - src_addr[1:0];
            half_base = src_addr[1] ? 2'd0 : 2'd2;
        end else begin
            lane      = src_addr[1:0];
            half_base = src_addr[1] ? 2'd2 : 2'd0;
        end

        case (size)
            2'd0: begin
                sel     = 4'b0001 << lane;
                st_data = {4{src_reg2[7:0]}};
                shamt   = lane;
            end
            2'd1: begin
                sel     = 4'b0011 << half_base;
                st_data = {2{src_reg2[15:0]}};
                shamt   = half_base;
            end
            default: begin
                sel     = 4'b1111;
                st_data = src_reg2;
                shamt   = 2'd0;
            end
        endcase

        ld_sh = mem_data_i >> {shamt, 3'b000};
        case (size)
            2'd0:    ld_ext = {{24{ld_signed & ld_sh[7]}}, ld_sh[7:0]};
            2'd1:    ld_ext = {{16{ld_signed & ld_sh[15]}}, ld_sh[15:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    logic              latch, wb_valid_d, wb_en, adel_d, ades_d, bus_err_d;
    logic [31:0]       wdata_d;
    logic [ADDR_W-1:0] badvaddr_d;

    // Next-state, handshake and write-back decision
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        latch       = 1'b0;
        mem_req_o   = 1'b0;
        stall_req_o = 1'b0;
        wb_valid_d  = 1'b0;
        wb_en       = 1'b0;
        adel_d      = 1'b0;
        ades_d      = 1'b0;
        bus_err_d   = 1'b0;
        wdata_d     = src_wdata;
        badvaddr_d  = badvaddr_o;
        case (state)
            S_IDLE: begin
                if (in_valid_i) begin
                    if (is_load || is_store) begin
                        if (misaligned) begin
                            wb_valid_d = 1'b1;
                            adel_d     = is_load;
                            ades_d     = is_store;
                            badvaddr_d = src_addr;
                        end else begin
                            mem_req_o   = 1'b1;
                            stall_req_o = 1'b1;
                            latch       = 1'b1;
                            state_d     = S_WAIT;
                            cnt_d       = '0;
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_en      = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                mem_req_o = 1'b1;
                cnt_d     = cnt + CNT_W'(1);
                if (mem_ack_i) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_en      = 1'b1;
                    if (is_load) begin
                        wdata_d = ld_ext;
                    end
                end else begin
                    stall_req_o = 1'b1;
                    // Counter steps onto TIMEOUT-1 at this edge: give up.
                    if (cnt == CNT_W'(TIMEOUT - 2)) begin
                        state_d    = S_IDLE;
                        cnt_d      = '0;
                        wb_valid_d = 1'b1;
                        bus_err_d  = 1'b1;
                        badvaddr_d = src_addr;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        mem_we_o   = mem_req_o & is_store;
        mem_sel_o  = mem_req_o ? sel : 4'b0000;
        mem_addr_o = mem_req_o ? {src_addr[ADDR_W-1:2], 2'b00} : '0;
        mem_data_o = mem_we_o ? st_data : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            op_q       <= aluop_i;
            addr_q     <= mem_addr_i;
            reg2_q     <= reg2_i;
            wdata_q    <= wdata_i;
            wd_q       <= wd_i;
            wreg_q     <= wreg_i;
            whilo_q    <= whilo_i;
            hi_q       <= hi_i;
            lo_q       <= lo_i;
            cp0_we_q   <= cp0_reg_we_i;
            cp0_addr_q <= cp0_reg_write_addr_i;
            cp0_data_q <= cp0_reg_data_i;
        end
    end

    // Write-back register; write enables only on a clean completion
    always_ff @(posedge clk) begin
        if (resetn) begin
            wb_valid_o           <= 1'b0;
            wdata_o              <= 32'd0;
            wd_o                 <= '0;
            wreg_o               <= 1'b0;
            whilo_o              <= 1'b0;
            hi_o                 <= 32'd0;
            lo_o                 <= 32'd0;
            cp0_reg_we_o         <= 1'b0;
            cp0_reg_write_addr_o <= 5'd0;
            cp0_reg_data_o       <= 32'd0;
            adel_o               <= 1'b0;
            ades_o               <= 1'b0;
            bus_err_o            <= 1'b0;
            badvaddr_o           <= '0;
        end else begin
            wb_valid_o           <= wb_valid_d;
            wdata_o              <= wdata_d;
            wd_o                 <= src_wd;
            wreg_o               <= wb_en & src_wreg & ~is_store;
            whilo_o              <= wb_en & src_whilo;
            hi_o                 <= src_hi;
            lo_o                 <= src_lo;
            cp0_reg_we_o         <= wb_en & src_cp0_we;
            cp0_reg_write_addr_o <= src_cp0_addr;
            cp0_reg_data_o       <= src_cp0_data;
            adel_o               <= adel_d;
            ades_o               <= ades_d;
            bus_err_o            <= bus_err_d;
            badvaddr_o           <= badvaddr_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: instance 0 little-endian with TIMEOUT=4,
// instance 1 big-endian with TIMEOUT=16, sharing one stimulus bus.
module tb_mem_stage_hs;

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;
    localparam logic [31:0] WDI   = 32'hCAFE_0001;
    localparam int unsigned NVEC  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, valid, wreg, whilo, cp0_we, ack;
    logic [7:0]  aluop;
    logic [31:0] alu_res, hi, lo, addr, store_data, cp0_data, rdata;
    logic [4:0]  dest, cp0_addr;

    logic [1:0]  req, we, stall, wb_valid, wb_wreg, wb_whilo, wb_cp0_we, adel, ades, bus_err;
    logic [3:0]  sel [2];
    logic [31:0] maddr [2];
    logic [31:0] mdata [2];
    logic [31:0] wb_data [2];
    logic [4:0]  wb_dest [2];
    logic [31:0] wb_hi [2];
    logic [31:0] wb_lo [2];
    logic [4:0]  wb_cp0_addr [2];
    logic [31:0] wb_cp0_data [2];
    logic [31:0] badvaddr [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_stage_hs #(
            .ADDR_W(32), .REG_AW(5), .BIG_ENDIAN(g == 1), .TIMEOUT((g == 1) ? 16 : 4)
        ) dut (
            .clk(clk), .resetn(resetn), .in_valid_i(valid), .aluop_i(aluop),
            .wdata_i(alu_res), .wd_i(dest), .wreg_i(wreg), .whilo_i(whilo),
            .hi_i(hi), .lo_i(lo), .mem_addr_i(addr), .reg2_i(store_data),
            .cp0_reg_we_i(cp0_we), .cp0_reg_write_addr_i(cp0_addr), .cp0_reg_data_i(cp0_data),
            .mem_req_o(req[g]), .mem_we_o(we[g]), .mem_sel_o(sel[g]), .mem_addr_o(maddr[g]),
            .mem_data_o(mdata[g]), .mem_data_i(rdata), .mem_ack_i(ack),
            .stall_req_o(stall[g]), .wb_valid_o(wb_valid[g]), .wdata_o(wb_data[g]),
            .wd_o(wb_dest[g]), .wreg_o(wb_wreg[g]), .whilo_o(wb_whilo[g]),
            .hi_o(wb_hi[g]), .lo_o(wb_lo[g]), .cp0_reg_we_o(wb_cp0_we[g]),
            .cp0_reg_write_addr_o(wb_cp0_addr[g]), .cp0_reg_data_o(wb_cp0_data[g]),
            .adel_o(adel[g]), .ades_o(ades[g]), .bus_err_o(bus_err[g]), .badvaddr_o(badvaddr[g])
        );
    end

    typedef struct {
        int          d;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] rd;
        int          ack_at;
        bit          early;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] mdata;
        logic [31:0] wdata;
        bit          wreg;
        bit          adel;
        bit          ades;
    } vec_t;

    vec_t vecs [NVEC];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        valid = 1'b1; aluop = v.op; addr = v.addr; store_data = v.st; alu_res = WDI;
        dest = 5'd9; wreg = 1'b1; whilo = 1'b1; cp0_we = 1'b1; cp0_addr = 5'd12;
        cp0_data = 32'h0BAD_F00D; rdata = v.rd; ack = v.early;
        @(negedge clk);
        if (v.adel || v.ades) begin
            chk({p, "_req"}, 32'(req[v.d]), 32'd0);
            chk({p, "_stall"}, 32'(stall[v.d]), 32'd0);
            @(posedge clk); #1;
            valid = 1'b0; ack = 1'b0;
            @(negedge clk);
            chk({p, "_wbv"}, 32'(wb_valid[v.d]), 32'd1);
            chk({p, "_adel"}, 32'(adel[v.d]), 32'(v.adel));
            chk({p, "_ades"}, 32'(ades[v.d]), 32'(v.ades));
            chk({p, "_badv"}, badvaddr[v.d], v.addr);
            chk({p, "_wreg"}, 32'(wb_wreg[v.d]), 32'd0);
            chk({p, "_whilo"}, 32'(wb_whilo[v.d]), 32'd0);
            chk({p, "_cp0we"}, 32'(wb_cp0_we[v.d]), 32'd0);
        end else begin
            chk({p, "_req"}, 32'(req[v.d]), 32'd1);
            chk({p, "_stall"}, 32'(stall[v.d]), 32'd1);
            chk({p, "_we"}, 32'(we[v.d]), 32'(v.we));
            chk({p, "_sel"}, 32'(sel[v.d]), 32'(v.sel));
            chk({p, "_maddr"}, maddr[v.d], v.addr & 32'hFFFF_FFFC);
            if (v.we) chk({p, "_mdata"}, mdata[v.d], v.mdata);
            @(posedge clk); #1;
            valid = 1'b0; aluop = 8'h00; addr = 32'hFFFF_FFFF; store_data = 32'd0;
            alu_res = 32'd0; dest = 5'd0; cp0_addr = 5'd0; ack = 1'b0;
            for (int j = 1; j <= v.ack_at; j++) begin
                if (j == v.ack_at) ack = 1'b1;
                @(negedge clk);
                chk($sformatf("%s_w%0d_stall", p, j), 32'(stall[v.d]), 32'(j != v.ack_at));
                chk($sformatf("%s_w%0d_req", p, j), 32'(req[v.d]), 32'd1);
                chk($sformatf("%s_w%0d_sel", p, j), 32'(sel[v.d]), 32'(v.sel));
                @(posedge clk); #1;
            end
            ack = 1'b0;
            @(negedge clk);
            chk({p, "_wbv"}, 32'(wb_valid[v.d]), 32'd1);
            chk({p, "_wdata"}, wb_data[v.d], v.wdata);
            chk({p, "_wreg"}, 32'(wb_wreg[v.d]), 32'(v.wreg));
            chk({p, "_dest"}, 32'(wb_dest[v.d]), 32'd9);
            chk({p, "_cp0addr"}, 32'(wb_cp0_addr[v.d]), 32'd12);
            chk({p, "_req_after"}, 32'(req[v.d]), 32'd0);
            chk({p, "_err"}, 32'({adel[v.d], ades[v.d], bus_err[v.d]}), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //           d  op      addr           st             rd             ack e  we sel    mdata          wdata          wreg adel ades
        vecs[0]  = '{0, OP_LW,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3, 0, 0, 4'hF, 32'h0,         32'hDEAD_BEEF, 1, 0, 0};
        vecs[1]  = '{0, OP_LB,  32'h0000_0101, 32'h0,         32'h1122_80FF, 1, 0, 0, 4'h2, 32'h0,         32'hFFFF_FF80, 1, 0, 0};
        vecs[2]  = '{0, OP_LBU, 32'h0000_0101, 32'h0,         32'h1122_80FF, 1, 0, 0, 4'h2, 32'h0,         32'h0000_0080, 1, 0, 0};
        vecs[3]  = '{0, OP_SH,  32'h0000_0102, 32'h0000_ABCD, 32'h0,         2, 0, 1, 4'hC, 32'hABCD_ABCD, WDI,           0, 0, 0};
        vecs[4]  = '{0, OP_LW,  32'h0000_1002, 32'h0,         32'h0,         0, 0, 0, 4'h0, 32'h0,         32'h0,         0, 1, 0};
        vecs[5]  = '{0, OP_SH,  32'h0000_1001, 32'h0000_ABCD, 32'h0,         0, 0, 1, 4'h0, 32'h0,         32'h0,         0, 0, 1};
        vecs[6]  = '{0, OP_LH,  32'h0000_1002, 32'h0,         32'h8001_7FFF, 1, 0, 0, 4'hC, 32'h0,         32'hFFFF_8001, 1, 0, 0};
        vecs[7]  = '{0, OP_LHU, 32'h0000_0100, 32'h0,         32'h1234_FEDC, 2, 0, 0, 4'h3, 32'h0,         32'h0000_FEDC, 1, 0, 0};
        vecs[8]  = '{0, OP_SB,  32'h0000_0103, 32'h0000_00A5, 32'h0,         1, 0, 1, 4'h8, 32'hA5A5_A5A5, WDI,           0, 0, 0};
        vecs[9]  = '{1, OP_SB,  32'h0000_0000, 32'h0000_003C, 32'h0,         1, 0, 1, 4'h8, 32'h3C3C_3C3C, WDI,           0, 0, 0};
        vecs[10] = '{1, OP_LH,  32'h0000_0002, 32'h0,         32'h1234_FEDC, 1, 0, 0, 4'h3, 32'h0,         32'hFFFF_FEDC, 1, 0, 0};
        vecs[11] = '{1, OP_LBU, 32'h0000_0001, 32'h0,         32'h1122_3344, 1, 0, 0, 4'h4, 32'h0,         32'h0000_0022, 1, 0, 0};
        vecs[12] = '{1, OP_LW,  32'h0000_0004, 32'h0,         32'h0102_0304, 2, 1, 0, 4'hF, 32'h0,         32'h0102_0304, 1, 0, 0};
        vecs[13] = '{0, OP_SW,  32'h0000_0200, 32'h89AB_CDEF, 32'h0,         1, 0, 1, 4'hF, 32'h89AB_CDEF, WDI,           0, 0, 0};
        vecs[14] = '{1, OP_LB,  32'h0000_0002, 32'h0,         32'h0000_9900, 1, 0, 0, 4'h2, 32'h0,         32'hFFFF_FF99, 1, 0, 0};
        vecs[15] = '{1, OP_LH,  32'h0000_0001, 32'h0,         32'h0,         0, 0, 0, 4'h0, 32'h0,         32'h0,         0, 1, 0};

        resetn = 1'b1; valid = 1'b0; aluop = 8'h00; alu_res = 32'd0; dest = 5'd0;
        wreg = 1'b0; whilo = 1'b0; hi = 32'd0; lo = 32'd0; addr = 32'd0; store_data = 32'd0;
        cp0_we = 1'b0; cp0_addr = 5'd0; cp0_data = 32'd0; rdata = 32'd0; ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_wbv", d), 32'(wb_valid[d]), 32'd0);
            chk($sformatf("rst%0d_req", d), 32'({req[d], stall[d]}), 32'd0);
            chk($sformatf("rst%0d_wdata", d), wb_data[d], 32'd0);
            chk($sformatf("rst%0d_flags", d), 32'({wb_wreg[d], adel[d], ades[d], bus_err[d]}), 32'd0);
        end

        // Non-memory op passes every field through in one cycle.
        @(posedge clk); #1;
        valid = 1'b1; aluop = 8'h25; alu_res = 32'h1357_9BDF; dest = 5'd17; wreg = 1'b1;
        whilo = 1'b1; hi = 32'hAAAA_0001; lo = 32'h5555_0002; cp0_we = 1'b1;
        cp0_addr = 5'd14; cp0_data = 32'h0000_00C3; addr = 32'h0000_0001;
        @(negedge clk);
        chk("pt_req", 32'({req[0], stall[0]}), 32'd0);
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        chk("pt_wbv", 32'(wb_valid[0]), 32'd1);
        chk("pt_wdata", wb_data[0], 32'h1357_9BDF);
        chk("pt_dest", 32'(wb_dest[0]), 32'd17);
        chk("pt_en", 32'({wb_wreg[0], wb_whilo[0], wb_cp0_we[0]}), 32'd7);
        chk("pt_hi", wb_hi[0], 32'hAAAA_0001);
        chk("pt_lo", wb_lo[0], 32'h5555_0002);
        chk("pt_cp0addr", 32'(wb_cp0_addr[0]), 32'd14);
        chk("pt_cp0data", wb_cp0_data[0], 32'h0000_00C3);
        chk("pt_adel", 32'(adel[0]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bubble_wbv", 32'(wb_valid[0]), 32'd0);
        chk("bubble_en", 32'({wb_wreg[0], wb_whilo[0], wb_cp0_we[0]}), 32'd0);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // Timeout: SW with ack never arriving on the TIMEOUT=4 instance.
        begin
            int req_cycles;
            bit seen;
            req_cycles = 0; seen = 1'b0;
            @(posedge clk); #1;
            valid = 1'b1; aluop = OP_SW; addr = 32'h0000_0300; store_data = 32'h1111_2222;
            wreg = 1'b1; whilo = 1'b1; cp0_we = 1'b1; ack = 1'b0;
            @(negedge clk);
            if (req[0]) req_cycles++;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(posedge clk); #1;
                valid = 1'b0;
                @(negedge clk);
                if (bus_err[0]) seen = 1'b1;
                else if (req[0]) req_cycles++;
            end
            chk("to_seen", 32'(seen), 32'd1);
            chk("to_req_cycles", 32'(req_cycles), 32'd4);
            chk("to_wbv", 32'(wb_valid[0]), 32'd1);
            chk("to_badv", badvaddr[0], 32'h0000_0300);
            chk("to_en", 32'({wb_wreg[0], wb_whilo[0], wb_cp0_we[0]}), 32'd0);
            chk("to_req_after", 32'(req[0]), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("to_pulse", 32'({bus_err[0], wb_valid[0]}), 32'd0);
        end

        // Reset while waiting, then a late ack that must be ignored.
        @(posedge clk); #1;
        valid = 1'b1; aluop = OP_SW; addr = 32'h0000_0300; ack = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        chk("rw_req_wait", 32'(req[0]), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0; ack = 1'b1; rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("rw_req", 32'({req[0], stall[0]}), 32'd0);
        chk("rw_wbv", 32'({wb_valid[0], bus_err[0]}), 32'd0);
        @(posedge clk); #1;
        ack = 1'b0;
        @(negedge clk);
        chk("rw_late_ack", 32'({wb_valid[0], req[0]}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Registered MIPS memory-access stage with a request/acknowledge data-memory handshake; sits between the EX/MEM register and the write-back path.
- Adds byte/halfword loads and stores with byte enables, and a selectable endian mode.
- Adds alignment exceptions, variable-latency memory with a pipeline stall request, and a bus-timeout error.
- Non-memory ops pass through with 1-cycle latency.

Parameters:
- ADDR_W, 32, data-memory address width; data width fixed at 32.
- REG_AW, 5, register-file address width.
- BIG_ENDIAN, 0, 0: byte k at lane k; 1: byte k at lane 3-k.
- TIMEOUT, 16, wait cycles before bus error; legal values ≥2.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous reset, active-high: asserted = 1 = `RstEnable.
- in_valid_i  in  1  EX/MEM slot holds an instruction.
- aluop_i  in  8  op code, define.v encodings: `EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP.
- wdata_i  in  32  ALU result.
- wd_i  in  REG_AW  destination register.
- wreg_i  in  1  register write enable.
- whilo_i  in  1  HI/LO write enable.
- hi_i, lo_i  in  32  HI/LO values.
- mem_addr_i  in  ADDR_W  effective address.
- reg2_i  in  32  store data.
- cp0_reg_we_i  in  1  CP0 write enable.
- cp0_reg_write_addr_i  in  5  CP0 write address.
- cp0_reg_data_i  in  32  CP0 write data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = store.
- mem_sel_o  out  4  byte enables.
- mem_addr_o  out  ADDR_W  word-aligned address, low 2 bits 0.
- mem_data_o  out  32  store data.
- mem_data_i  in  32  load data, valid with ack.
- mem_ack_i  in  1  memory completion.
- stall_req_o  out  1  combinational; upstream holds.
- wb_valid_o  out  1  write-back slot valid.
- wdata_o  out  32  write-back data.
- wd_o  out  REG_AW  destination register.
- wreg_o  out  1  register write enable.
- whilo_o  out  1  HI/LO write enable.
- hi_o, lo_o  out  32  HI/LO values.
- cp0_reg_we_o  out  1  CP0 write enable.
- cp0_reg_write_addr_o  out  5  CP0 write address.
- cp0_reg_data_o  out  32  CP0 write data.
- adel_o  out  1  load address error, 1-cycle pulse with wb_valid_o.
- ades_o  out  1  store address error, 1-cycle pulse with wb_valid_o.
- bus_err_o  out  1  timeout error, 1-cycle pulse with wb_valid_o.
- badvaddr_o  out  ADDR_W  faulting address.

Behaviour:
- Reset:
  - All outputs 0, state IDLE, wait counter 0.
  - Reset asserted in WAIT: mem_req_o drops at that edge; no write-back; a late ack is ignored.
- FSM states: IDLE, WAIT.
- IDLE, non-memory op with in_valid_i:
  - Register all *_i fields into the matching *_o next edge; wb_valid_o=1.
  - in_valid_i=0: wb_valid_o=0 and all write enables 0.
- IDLE, aligned memory op:
  - Combinationally assert mem_req_o, we, sel, aligned addr and data; stall_req_o=1.
  - Go to WAIT at the next edge; latch all inputs.
- Alignment rules:
  - Halfword: addr[0]=0. Word: addr[1:0]=0. Byte ops are always aligned.
  - Misaligned op: no request, no stall.
  - Next edge: wb_valid_o=1, adel_o (loads) or ades_o (stores)=1, badvaddr_o=addr.
  - wreg_o, whilo_o and cp0_reg_we_o forced 0.
- WAIT:
  - Memory outputs held from latched values; counter increments each cycle.
  - stall_req_o=1 except in a cycle with mem_ack_i=1.
  - Ack cycle: drop mem_req_o next edge and return to IDLE.
  - Same edge: wb_valid_o=1; wdata_o = extracted load data (loads) or wdata_i (stores); stores force wreg_o=0.
  - Ack in the accept cycle, i.e. in IDLE, is ignored; the earliest completion is the first WAIT cycle.
- Timeout: counter reaches TIMEOUT-1 with no ack.
  - Next edge: mem_req_o=0, IDLE, wb_valid_o=1, bus_err_o=1, badvaddr_o=addr.
  - All write enables 0.
- Lane index L:
  - BIG_ENDIAN=0: L=addr[1:0]. BIG_ENDIAN=1: L=3-addr[1:0].
  - Halfwords occupy lanes L and L+1 (LE) or L-1 and L (BE); LE lane pair addr[1]*2, BE lane pair 2-addr[1]*2.
- Store data and enables:
  - SB: data={4{reg2_i[7:0]}}, sel=one-hot lane.
  - SH: data={2{reg2_i[15:0]}}, sel=0011 or 1100.
  - SW: data=reg2_i, sel=1111.
- Load enables and extension:
  - Loads: sel as for stores of the same size.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- CP0 fields pass through with the instruction.

Test Plan:
- LW at 0x100, ack on 3rd WAIT cycle, data 0xDEADBEEF:
  - stall_req_o high 3 cycles, low in the ack cycle.
  - Next cycle: wdata_o=0xDEADBEEF, wreg_o=1, sel=1111.
- LE: LB at 0x101, data 0x112280FF -> sel=0010, wdata_o=0xFFFFFF80. LBU -> 0x00000080.
- LE: SH at 0x102, reg2_i=0x0000ABCD -> sel=1100, mem_data_o=0xABCDABCD, we=1; after ack wreg_o=0.
- LW at 0x1002 -> no mem_req_o; next cycle adel_o=1, badvaddr_o=0x1002, wreg_o=0.
- TIMEOUT=4, SW with ack held low:
  - Req high 4 cycles, then bus_err_o=1, wreg_o=0.
  - Reset asserted mid-WAIT instead: req drops, no wb_valid_o.
- BIG_ENDIAN=1: SB at 0x0 -> sel=1000. LH at 0x2, data 0x1234FEDC -> wdata_o=0xFFFFFEDC.
